fifo_flex: RTL and testbench

- Parametrised synchronous FIFO; next generation of the single-clock circular-buffer FIFO used in the IO circuits (UART RX/TX buffering, MMIO queues).
- Adds selectable read mode (registered or first-word-fall-through), occupancy count, and programmable almost-full/almost-empty thresholds.
- Adds a synchronous flush, sticky overflow/underflow error flags, and read-during-full write acceptance.

---
 rtl/fifo_flex.sv | 112 +++++++++++
 tb/tb_fifo_flex.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_flex.sv
// Parametrised single-clock circular-buffer FIFO with registered or fall-through read,
// occupancy count, programmable almost-full/almost-empty thresholds, flush and sticky error flags.
module fifo_flex #(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 32,
    parameter int POINTER_WIDTH = $clog2(DEPTH),
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = DEPTH - 4,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         din,
    output logic                     full,
    output logic                     almost_full,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     almost_empty,
    output logic [POINTER_WIDTH:0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int PW = POINTER_WIDTH;
    localparam logic [PW:0] L_AFULL  = AFULL_THRESH[PW:0];
    localparam logic [PW:0] L_AEMPTY = AEMPTY_THRESH[PW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW:0]      r_wrPtr;
    logic [PW:0]      r_rdPtr;
    logic             r_overflow;
    logic             r_underflow;

    logic [PW:0]      w_count;
    logic [PW-1:0]    w_wrIdx;
    logic [PW-1:0]    w_rdIdx;
    logic             w_full;
    logic             w_empty;
    logic             w_rdAcc;
    logic             w_wrAcc;

    assign w_wrIdx = r_wrPtr[PW-1:0];
    assign w_rdIdx = r_rdPtr[PW-1:0];
    assign w_count = r_wrPtr - r_rdPtr;
    assign w_full  = (r_wrPtr[PW] != r_rdPtr[PW]) && (w_wrIdx == w_rdIdx);
    assign w_empty = (r_wrPtr == r_rdPtr);

    // A write into a full FIFO is only safe when the head slot is being vacated this cycle.
    assign w_rdAcc = rd_en && !w_empty;
    assign w_wrAcc = wr_en && (!w_full || w_rdAcc);

    assign full         = w_full;
    assign empty        = w_empty;
    assign count        = w_count;
    assign almost_full  = (w_count >= L_AFULL);
    assign almost_empty = (w_count <= L_AEMPTY);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else if (clr) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_wrAcc) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_rdAcc) r_rdPtr <= r_rdPtr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clr) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en && !w_wrAcc) r_overflow  <= 1'b1;
            if (rd_en && w_empty)  r_underflow <= 1'b1;
        end
    end

    // Storage is deliberately left out of reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (w_wrAcc && !clr) r_mem[w_wrIdx] <= din;
    end

    if (FWFT == 0) begin : g_regRead
        logic [WIDTH-1:0] r_dout;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_dout <= '0;
            end else if (clr) begin
                r_dout <= '0;
            end else if (w_rdAcc) begin
                r_dout <= r_mem[w_rdIdx];
            end
        end

        assign dout = r_dout;
    end else begin : g_fwft
        assign dout = r_mem[w_rdIdx];
    end

endmodule

// File: tb/tb_fifo_flex.sv
// Self-checking bench for fifo_flex: registered-read (DEPTH=32), fall-through (DEPTH=8)
// and a randomised DEPTH=4 instance checked against a queue model.
module tb_fifo_flex;

    logic clk;
    logic rst_n;

    logic       aClr, aWr, aRd;
    logic [7:0] aDin, aDout;
    logic       aFull, aAfull, aEmpty, aAempty, aOvf, aUdf;
    logic [5:0] aCount;

    logic       bClr, bWr, bRd;
    logic [7:0] bDin, bDout;
    logic       bFull, bAfull, bEmpty, bAempty, bOvf, bUdf;
    logic [3:0] bCount;

    logic       cClr, cWr, cRd;
    logic [7:0] cDin, cDout;
    logic       cFull, cAfull, cEmpty, cAempty, cOvf, cUdf;
    logic [2:0] cCount;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        logic       wr;
        logic       rd;
        logic       clr;
        logic [7:0] din;
        int         expCount;
        logic       expEmpty;
        logic       expFull;
        logic       expAempty;
        logic       expAfull;
        logic       expOvf;
        logic       expUdf;
        logic [7:0] expDout;
    } vector_t;

    vector_t vecs [9];

    fifo_flex #(.WIDTH(8), .DEPTH(32), .FWFT(0)) dutA (
        .clk(clk), .rst_n(rst_n), .clr(aClr), .wr_en(aWr), .din(aDin),
        .full(aFull), .almost_full(aAfull), .rd_en(aRd), .dout(aDout),
        .empty(aEmpty), .almost_empty(aAempty), .count(aCount),
        .overflow(aOvf), .underflow(aUdf)
    );

    fifo_flex #(.WIDTH(8), .DEPTH(8), .FWFT(1)) dutB (
        .clk(clk), .rst_n(rst_n), .clr(bClr), .wr_en(bWr), .din(bDin),
        .full(bFull), .almost_full(bAfull), .rd_en(bRd), .dout(bDout),
        .empty(bEmpty), .almost_empty(bAempty), .count(bCount),
        .overflow(bOvf), .underflow(bUdf)
    );

    fifo_flex #(.WIDTH(8), .DEPTH(4), .FWFT(0), .AFULL_THRESH(3), .AEMPTY_THRESH(1)) dutC (
        .clk(clk), .rst_n(rst_n), .clr(cClr), .wr_en(cWr), .din(cDin),
        .full(cFull), .almost_full(cAfull), .rd_en(cRd), .dout(cDout),
        .empty(cEmpty), .almost_empty(cAempty), .count(cCount),
        .overflow(cOvf), .underflow(cUdf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drives one instance for a single clock and returns #1 after the edge.
    task automatic applyStimulus(input int sel, input logic wr, input logic rd, input logic clr,
                                 input logic [7:0] din);
        aWr = 0; aRd = 0; aClr = 0; aDin = '0;
        bWr = 0; bRd = 0; bClr = 0; bDin = '0;
        cWr = 0; cRd = 0; cClr = 0; cDin = '0;
        case (sel)
            0: begin aWr = wr; aRd = rd; aClr = clr; aDin = din; end
            1: begin bWr = wr; bRd = rd; bClr = clr; bDin = din; end
            default: begin cWr = wr; cRd = rd; cClr = clr; cDin = din; end
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic checkA(input string tag, input int cnt, input logic e, input logic f,
                          input logic ae, input logic af, input logic ovf, input logic udf);
        checkOutput({tag, ".count"}, 32'(aCount), cnt);
        checkOutput({tag, ".empty"}, 32'(aEmpty), 32'(e));
        checkOutput({tag, ".full"}, 32'(aFull), 32'(f));
        checkOutput({tag, ".almost_empty"}, 32'(aAempty), 32'(ae));
        checkOutput({tag, ".almost_full"}, 32'(aAfull), 32'(af));
        checkOutput({tag, ".overflow"}, 32'(aOvf), 32'(ovf));
        checkOutput({tag, ".underflow"}, 32'(aUdf), 32'(udf));
    endtask

    task automatic checkB(input string tag, input int cnt, input logic e, input logic f,
                          input logic ovf, input logic udf);
        checkOutput({tag, ".count"}, 32'(bCount), cnt);
        checkOutput({tag, ".empty"}, 32'(bEmpty), 32'(e));
        checkOutput({tag, ".full"}, 32'(bFull), 32'(f));
        checkOutput({tag, ".almost_empty"}, 32'(bAempty), 32'(cnt <= 4));
        checkOutput({tag, ".almost_full"}, 32'(bAfull), 32'(cnt >= 4));
        checkOutput({tag, ".overflow"}, 32'(bOvf), 32'(ovf));
        checkOutput({tag, ".underflow"}, 32'(bUdf), 32'(udf));
    endtask

    initial begin
        logic [7:0] model [$];
        logic [7:0] expDout;
        logic [7:0] expHead;
        logic       mOvf, mUdf, mEmpty, mFull, rdAcc, wrAcc;
        logic       rWr, rRd, rClr;
        logic [7:0] rDin;

        // wr rd clr din | count empty full aempty afull ovf udf dout
        vecs[0] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 8'h5C, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5C};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 8'h77, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 8'h33, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 8'h44, 2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 8'h12, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[8] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h12};

        aWr = 0; aRd = 0; aClr = 0; aDin = '0;
        bWr = 0; bRd = 0; bClr = 0; bDin = '0;
        cWr = 0; cRd = 0; cClr = 0; cDin = '0;
        rst_n = 1'b0;
        #12;
        checkA("reset", 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("reset.dout", 32'(aDout), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] table vectors on registered-read instance");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(0, vecs[i].wr, vecs[i].rd, vecs[i].clr, vecs[i].din);
            checkA($sformatf("vec%0d", i), vecs[i].expCount, vecs[i].expEmpty, vecs[i].expFull,
                   vecs[i].expAempty, vecs[i].expAfull, vecs[i].expOvf, vecs[i].expUdf);
            checkOutput($sformatf("vec%0d.dout", i), 32'(aDout), 32'(vecs[i].expDout));
        end

        $display("[TB] asynchronous reset with five words held");
        for (int i = 0; i < 6; i++) applyStimulus(0, 1'b1, 1'b0, 1'b0, 8'hA0 + 8'(i));
        applyStimulus(0, 1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("prereset.count", 32'(aCount), 5);
        checkOutput("prereset.dout", 32'(aDout), 32'hA0);
        #2 rst_n = 1'b0;
        #1;
        checkA("asyncreset", 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("asyncreset.dout", 32'(aDout), 32'h0);
        #2 rst_n = 1'b1;

        $display("[TB] fill to full with threshold tracking");
        for (int i = 0; i < 32; i++) begin
            applyStimulus(0, 1'b1, 1'b0, 1'b0, 8'(i));
            checkA($sformatf("fill%0d", i), i + 1, 1'b0, (i == 31), (i + 1 <= 4), (i + 1 >= 28),
                   1'b0, 1'b0);
        end

        applyStimulus(0, 1'b1, 1'b0, 1'b0, 8'hAA);
        checkA("fullwrite", 32, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 8'hBB);
        checkA("fullrw", 32, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("fullrw.dout", 32'(aDout), 32'h00);

        for (int k = 0; k < 32; k++) begin
            expDout = (k < 31) ? 8'(k + 1) : 8'hBB;
            applyStimulus(0, 1'b0, 1'b1, 1'b0, 8'h00);
            checkA($sformatf("drain%0d", k), 31 - k, (k == 31), 1'b0, (31 - k <= 4), (31 - k >= 28),
                   1'b1, 1'b0);
            checkOutput($sformatf("drain%0d.dout", k), 32'(aDout), 32'(expDout));
        end

        $display("[TB] fall-through instance with flush");
        applyStimulus(1, 1'b1, 1'b0, 1'b0, 8'h11);
        checkB("ft1", 1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("ft1.dout", 32'(bDout), 32'h11);
        applyStimulus(1, 1'b1, 1'b0, 1'b0, 8'h22);
        checkB("ft2", 2, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("ft2.dout", 32'(bDout), 32'h11);
        applyStimulus(1, 1'b0, 1'b1, 1'b0, 8'h00);
        checkB("ft3", 1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("ft3.dout", 32'(bDout), 32'h22);
        applyStimulus(1, 1'b0, 1'b1, 1'b0, 8'h00);
        checkB("ft4", 0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1, 1'b0, 1'b1, 1'b0, 8'h00);
        checkB("ft5", 0, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1, 1'b1, 1'b0, 1'b0, 8'h44);
        checkB("ft6", 1, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("ft6.dout", 32'(bDout), 32'h44);
        applyStimulus(1, 1'b1, 1'b0, 1'b1, 8'h99);
        checkB("ftclr", 0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1, 1'b1, 1'b0, 1'b0, 8'h55);
        checkB("ft8", 1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("ft8.dout", 32'(bDout), 32'h55);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1, 1'b1, 1'b0, 1'b0, 8'h60 + 8'(i));
            checkB($sformatf("ftfill%0d", i), i + 2, 1'b0, (i == 6), 1'b0, 1'b0);
        end
        applyStimulus(1, 1'b1, 1'b0, 1'b0, 8'hEE);
        checkB("ftovf", 8, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("ftovf.dout", 32'(bDout), 32'h55);
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 8'hFF);
        checkB("ftfullrw", 8, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) begin
            expHead = (k < 7) ? 8'h60 + 8'(k) : 8'hFF;
            checkOutput($sformatf("fthead%0d", k), 32'(bDout), 32'(expHead));
            applyStimulus(1, 1'b0, 1'b1, 1'b0, 8'h00);
        end
        checkB("ftdrained", 0, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1, 1'b0, 1'b0, 1'b1, 8'h00);
        checkB("ftclr2", 0, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("[TB] random run on DEPTH=4 against queue model");
        mOvf = 1'b0;
        mUdf = 1'b0;
        expDout = 8'h00;
        for (int n = 0; n < 1000; n++) begin
            rWr  = ($urandom_range(0, 99) < 55);
            rRd  = ($urandom_range(0, 99) < 50);
            rClr = ($urandom_range(0, 63) == 0);
            rDin = 8'($urandom_range(0, 255));
            mEmpty = (model.size() == 0);
            mFull  = (model.size() == 4);
            if (rClr) begin
                model.delete();
                mOvf = 1'b0;
                mUdf = 1'b0;
                expDout = 8'h00;
            end else begin
                rdAcc = rRd && !mEmpty;
                wrAcc = rWr && (!mFull || rdAcc);
                if (rWr && !wrAcc) mOvf = 1'b1;
                if (rRd && mEmpty) mUdf = 1'b1;
                if (rdAcc) expDout = model.pop_front();
                if (wrAcc) model.push_back(rDin);
            end
            applyStimulus(2, rWr, rRd, rClr, rDin);
            checkOutput($sformatf("rnd%0d.count", n), 32'(cCount), model.size());
            checkOutput($sformatf("rnd%0d.empty", n), 32'(cEmpty), 32'(model.size() == 0));
            checkOutput($sformatf("rnd%0d.full", n), 32'(cFull), 32'(model.size() == 4));
            checkOutput($sformatf("rnd%0d.aempty", n), 32'(cAempty), 32'(model.size() <= 1));
            checkOutput($sformatf("rnd%0d.afull", n), 32'(cAfull), 32'(model.size() >= 3));
            checkOutput($sformatf("rnd%0d.ovf", n), 32'(cOvf), 32'(mOvf));
            checkOutput($sformatf("rnd%0d.udf", n), 32'(cUdf), 32'(mUdf));
            checkOutput($sformatf("rnd%0d.dout", n), 32'(cDout), 32'(expDout));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
